// File: rtl/sequential_divider_if.sv
// Handshake and data bundle for the sequential divider.
// The master issues requests (start + operands); the slave returns status and results.
interface sequential_divider_if #(
    parameter int DVD_W = 8,
    parameter int DVS_W = 4
);
    logic             start;
    logic [DVD_W-1:0] dividend;
    logic [DVS_W-1:0] divisor;
    logic             busy;
    logic             done;
    logic [DVD_W-1:0] quotient;
    logic [DVS_W-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/sequential_divider.sv
// Unsigned restoring divider producing one quotient bit per clock, MSB first.
// A zero divisor short-circuits straight to DONE with an all-ones quotient.
module sequential_divider #(
    parameter int DVD_W = 8,
    parameter int DVS_W = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    sequential_divider_if.slave    bus
);
    localparam int CNT_W = $clog2(DVD_W + 1);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DVD_W - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state_reg;
    logic [DVD_W-1:0] shift_reg;      // dividend bits shift out at the top, quotient bits shift in at the bottom
    logic [DVS_W-1:0] dvs_reg;
    logic [DVS_W:0]   prem_reg;       // partial remainder, one bit wider than the divisor
    logic [CNT_W-1:0] cnt_reg;
    logic [DVD_W-1:0] quotient_reg;
    logic [DVS_W-1:0] remainder_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             dbz_reg;

    logic [DVS_W:0]   shifted;
    logic             ge;
    logic [DVS_W:0]   prem_next;
    logic [DVD_W-1:0] shift_next;

    // One restoring step: bring down the next dividend bit, trial-subtract the divisor.
    always_comb begin
        shifted    = {prem_reg[DVS_W-1:0], shift_reg[DVD_W-1]};
        ge         = (shifted >= {1'b0, dvs_reg});
        prem_next  = ge ? (shifted - {1'b0, dvs_reg}) : shifted;
        shift_next = {shift_reg[DVD_W-2:0], ge};
    end

    // Control FSM, datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            shift_reg     <= '0;
            dvs_reg       <= '0;
            prem_reg      <= '0;
            cnt_reg       <= '0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            dbz_reg       <= 1'b0;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    if (bus.start) begin
                        shift_reg <= bus.dividend;
                        dvs_reg   <= bus.divisor;
                        prem_reg  <= '0;
                        cnt_reg   <= '0;
                        if (bus.divisor == '0) begin
                            // No iteration needed: publish the saturated result right away.
                            state_reg     <= DONE;
                            quotient_reg  <= '1;
                            remainder_reg <= '0;
                            busy_reg      <= 1'b0;
                            done_reg      <= 1'b1;
                            dbz_reg       <= 1'b1;
                        end else begin
                            state_reg <= BUSY;
                            busy_reg  <= 1'b1;
                            done_reg  <= 1'b0;
                            dbz_reg   <= 1'b0;
                        end
                    end
                end
                BUSY: begin
                    // start is deliberately not looked at here.
                    shift_reg <= shift_next;
                    prem_reg  <= prem_next;
                    cnt_reg   <= cnt_reg + 1'b1;
                    if (cnt_reg == LAST_STEP) begin
                        state_reg     <= DONE;
                        quotient_reg  <= shift_next;
                        remainder_reg <= prem_next[DVS_W-1:0];
                        busy_reg      <= 1'b0;
                        done_reg      <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy        = busy_reg;
    assign bus.done        = done_reg;
    assign bus.quotient    = quotient_reg;
    assign bus.remainder   = remainder_reg;
    assign bus.div_by_zero = dbz_reg;
endmodule

// File: tb/tb_sequential_divider.sv
// Bench for sequential_divider: directed vector table, hand-written corner
// sequences (ignored start, mid-operation reset, result hold) and random ops
// checked against an arithmetic reference model.
module tb_sequential_divider;
    localparam int DVD_W = 8;
    localparam int DVS_W = 4;
    localparam int FULL_LAT = DVD_W;
    localparam int TIMEOUT = 20;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    sequential_divider_if #(.DVD_W(DVD_W), .DVS_W(DVS_W)) bus ();

    sequential_divider #(.DVD_W(DVD_W), .DVS_W(DVS_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] dd;
        logic [3:0] ds;
        logic [7:0] q;
        logic [3:0] r;
        logic       dbz;
        int         lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: plain integer division, with the saturating rule for a zero divisor.
    task automatic model(input logic [7:0] dd, input logic [3:0] ds,
                         output logic [7:0] q, output logic [3:0] r,
                         output logic dbz, output int lat);
        if (ds == 0) begin
            q = 8'hFF; r = 4'd0; dbz = 1'b1; lat = 0;
        end else begin
            q = 8'(int'(dd) / int'(ds));
            r = 4'(int'(dd) % int'(ds));
            dbz = 1'b0; lat = FULL_LAT;
        end
    endtask

    // Wait (bounded) for done; entered right after the accepting edge's negedge.
    task automatic wait_done(output int lat);
        lat = 0;
        while (!bus.done && lat < TIMEOUT) begin
            @(negedge clk);
            lat++;
        end
    endtask

    // Issue one request at a negedge and check the full response. Returns on a negedge with done high.
    task automatic run_op(input logic [7:0] dd, input logic [3:0] ds,
                          input logic [7:0] eq, input logic [3:0] er,
                          input logic edbz, input int elat, input string tag);
        int lat;
        bus.dividend = dd;
        bus.divisor  = ds;
        bus.start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        check($sformatf("%s busy_done_after_accept", tag), {30'd0, bus.busy, bus.done},
              (elat == 0) ? 32'd1 : 32'd2);
        wait_done(lat);
        check($sformatf("%s latency", tag), lat, elat);
        check($sformatf("%s quotient", tag), bus.quotient, eq);
        check($sformatf("%s remainder", tag), bus.remainder, er);
        check($sformatf("%s div_by_zero", tag), bus.div_by_zero, edbz);
        check($sformatf("%s busy_in_done", tag), bus.busy, 1'b0);
        $display("op %s: %0d/%0d -> q=%0d r=%0d dbz=%0d lat=%0d", tag, dd, ds,
                 bus.quotient, bus.remainder, bus.div_by_zero, lat);
    endtask

    task automatic check_all_zero(input string tag);
        check($sformatf("%s busy", tag), bus.busy, 1'b0);
        check($sformatf("%s done", tag), bus.done, 1'b0);
        check($sformatf("%s quotient", tag), bus.quotient, 8'd0);
        check($sformatf("%s remainder", tag), bus.remainder, 4'd0);
        check($sformatf("%s div_by_zero", tag), bus.div_by_zero, 1'b0);
    endtask

    initial begin
        vec_t vecs[10];
        int lat;
        logic [7:0] dd, eq;
        logic [3:0] ds, er;
        logic edbz;
        int elat;

        n_checks = 0;
        n_fail   = 0;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;

        vecs[0] = '{8'd15,  4'd3,  8'd5,   4'd0, 1'b0, 8};
        vecs[1] = '{8'd200, 4'd7,  8'd28,  4'd4, 1'b0, 8};
        vecs[2] = '{8'd255, 4'd15, 8'd17,  4'd0, 1'b0, 8};  // back-to-back after 200/7
        vecs[3] = '{8'd100, 4'd0,  8'hFF,  4'd0, 1'b1, 0};
        vecs[4] = '{8'd20,  4'd2,  8'd10,  4'd0, 1'b0, 8};
        vecs[5] = '{8'd3,   4'd7,  8'd0,   4'd3, 1'b0, 8};
        vecs[6] = '{8'd0,   4'd5,  8'd0,   4'd0, 1'b0, 8};
        vecs[7] = '{8'd255, 4'd1,  8'd255, 4'd0, 1'b0, 8};
        vecs[8] = '{8'd9,   4'd9,  8'd1,   4'd0, 1'b0, 8};
        vecs[9] = '{8'd254, 4'd15, 8'd16,  4'd14, 1'b0, 8};

        // Reset state
        rst_n = 1'b0;
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("idle_after_reset");

        // Directed table; entries run back-to-back, each start issued on the cycle done is seen.
        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].dd, vecs[i].ds, vecs[i].q, vecs[i].r, vecs[i].dbz, vecs[i].lat,
                   $sformatf("vec%0d", i));
        end

        // Results hold in DONE while no start arrives.
        repeat (3) @(negedge clk);
        check("hold done", bus.done, 1'b1);
        check("hold quotient", bus.quotient, 8'd16);
        check("hold remainder", bus.remainder, 4'd14);

        // Start during BUSY is ignored: 20/2, then 14/2 presented at cycle 3.
        bus.dividend = 8'd20;
        bus.divisor  = 4'd2;
        bus.start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        bus.dividend = 8'd14;
        bus.divisor  = 4'd2;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("ignored_start busy", bus.busy, 1'b1);
        lat = 3;
        while (!bus.done && lat < TIMEOUT) begin
            @(negedge clk);
            lat++;
        end
        check("ignored_start latency", lat, FULL_LAT);
        check("ignored_start quotient", bus.quotient, 8'd10);
        check("ignored_start remainder", bus.remainder, 4'd0);
        $display("op ignored_start: 20/2 (14/2 ignored) -> q=%0d r=%0d lat=%0d",
                 bus.quotient, bus.remainder, lat);

        // Reset in the middle of 255/15, start held high during reset.
        bus.dividend = 8'd255;
        bus.divisor  = 4'd15;
        bus.start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        bus.start = 1'b1;
        #1;
        check_all_zero("midop_reset");
        @(negedge clk);
        bus.start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("after_release");
        $display("op midop_reset: 255/15 abandoned");
        run_op(8'd14, 4'd2, 8'd7, 4'd0, 1'b0, FULL_LAT, "post_reset");

        // Random ops against the reference model, with random idle gaps.
        for (int i = 0; i < 40; i++) begin
            dd = 8'($urandom_range(0, 255));
            ds = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
            model(dd, ds, eq, er, edbz, elat);
            run_op(dd, ds, eq, er, edbz, elat, $sformatf("rnd%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
